// File: rtl/imem_loader.sv
// Byte-serial instruction-memory loader: receives a counted, XOR-checked frame,
// writes 16-bit words to consecutive addresses, and holds the CPU in reset until done.
module imem_loader #(
  parameter int DEPTH = 256
) (
  input  logic        clk_pi,
  input  logic        reset_pi,
  input  logic        start_pi,
  input  logic        byte_valid_pi,
  input  logic [7:0]  byte_data_pi,
  output logic        byte_ready_po,
  output logic        imem_we_po,
  output logic [15:0] imem_addr_po,
  output logic [15:0] imem_wdata_po,
  output logic        cpu_reset_po,
  output logic        load_done_po,
  output logic        error_po,
  output logic [15:0] word_count_po,
  output logic [2:0]  dbg_state_po
);

  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_HI  = 3'd1,
    CNT_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } state_t;

  // Handshake: a byte transfers on a rising clk edge where byte_valid_pi and
  // byte_ready_po are both high; the host may hold valid low to pause indefinitely.

  state_t             state, next_state;
  logic [7:0]         hi_byte;
  logic [7:0]         xor_sum;
  logic [IDX_W-1:0]   word_idx;
  logic               accept;
  logic               start_ok;
  logic [15:0]        frame_n;
  logic               oversize;
  logic               last_word;

  assign accept    = byte_valid_pi && byte_ready_po;
  assign start_ok  = start_pi && (state == IDLE || state == DONE || state == ERROR);
  assign frame_n   = {hi_byte, byte_data_pi};
  assign oversize  = {1'b0, frame_n} > DEPTH_W;
  assign last_word = (16'(word_idx) == word_count_po - 16'd1);
  assign dbg_state_po = state;

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok) next_state = CNT_HI;
      CNT_HI:  if (accept) next_state = CNT_LO;
      CNT_LO: begin
        if (accept) begin
          if (oversize)              next_state = ERROR;
          else if (frame_n == 16'd0) next_state = CHECK;
          else                       next_state = DATA_HI;
        end
      end
      DATA_HI: if (accept) next_state = DATA_LO;
      DATA_LO: if (accept) next_state = last_word ? CHECK : DATA_HI;
      CHECK:   if (accept) next_state = (byte_data_pi == xor_sum) ? DONE : ERROR;
      DONE:    if (start_ok) next_state = CNT_HI;
      ERROR:   if (start_ok) next_state = CNT_HI;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs are registered copies of the next state so they line up with it.
  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      byte_ready_po <= 1'b0;
      imem_we_po    <= 1'b0;
      imem_addr_po  <= 16'd0;
      imem_wdata_po <= 16'd0;
      cpu_reset_po  <= 1'b1;
      load_done_po  <= 1'b0;
      error_po      <= 1'b0;
      word_count_po <= 16'd0;
      hi_byte       <= 8'd0;
      xor_sum       <= 8'd0;
      word_idx      <= '0;
    end else begin
      imem_we_po    <= 1'b0;
      byte_ready_po <= (next_state == CNT_HI) || (next_state == CNT_LO) ||
                       (next_state == DATA_HI) || (next_state == DATA_LO) ||
                       (next_state == CHECK);
      cpu_reset_po  <= (next_state != DONE);
      load_done_po  <= (next_state == DONE);
      error_po      <= (next_state == ERROR);

      if (start_ok) begin
        word_idx      <= '0;
        xor_sum       <= 8'd0;
        word_count_po <= 16'd0;
      end

      if (accept) begin
        case (state)
          CNT_HI:  hi_byte <= byte_data_pi;
          CNT_LO:  word_count_po <= frame_n;
          DATA_HI: begin
            hi_byte <= byte_data_pi;
            xor_sum <= xor_sum ^ byte_data_pi;
          end
          DATA_LO: begin
            imem_we_po    <= 1'b1;
            imem_addr_po  <= 16'(word_idx);
            imem_wdata_po <= frame_n;
            xor_sum       <= xor_sum ^ byte_data_pi;
            word_idx      <= word_idx + {{(IDX_W-1){1'b0}}, 1'b1};
          end
          default: ;
        endcase
      end
    end
  end

endmodule
